ahb_apb_bridge_param: RTL and testbench
=======================================

Name: ahb_apb_bridge_param

Overview:
Parametrised AHB-Lite slave to APB master bridge; the next generation of the fixed-width single-address APB master.
- Generalised address/data width.
- Adds pready wait states, pslverr to AHB ERROR translation, byte strobes, and an optional access timeout.
- Sits between the AHB-Lite interconnect and a single APB peripheral segment.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width; 8, 16, 32 or 64
TIMEOUT_CYC, 0, max ACCESS cycles without pready; 0 disables the timeout

Ports:
clk  in  1  single clock for AHB and APB sides
preset_n  in  1  asynchronous active-low reset
hsel_i  in  1  AHB slave select
haddr_i  in  ADDR_W  AHB address
htrans_i  in  2  AHB transfer type
hwrite_i  in  1  AHB write
hsize_i  in  3  AHB transfer size
hwdata_i  in  DATA_W  AHB write data (data phase)
hready_i  in  1  AHB bus ready
hreadyout_o  out  1  bridge ready
hresp_o  out  1  0=OKAY, 1=ERROR
hrdata_o  out  DATA_W  read data
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
pstrb_o  out  DATA_W/8  APB byte strobes
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Reset (async, preset_n=0, any state): hreadyout_o=1, hresp_o=0; hrdata_o, paddr_o, pwdata_o, pstrb_o = 0; psel_o, penable_o, pwrite_o = 0; state=ST_IDLE. An in-flight transfer is dropped.
- Valid transfer: hsel_i & hready_i & htrans_i[1] in ST_IDLE. IDLE/BUSY transfers get a zero-wait OKAY.
- ST_IDLE: hreadyout_o=1. On a valid transfer, register haddr_i→paddr_o, hwrite_i→pwrite_o, and pstrb from hsize/haddr (zero for reads).
  - hsize_i > log2(DATA_W/8): go to ST_ERR1; no APB access.
  - Write: go to ST_WDATA.
  - Read: go to ST_SETUP.
- ST_WDATA: hreadyout_o=0; capture hwdata_i→pwdata_o; go to ST_SETUP.
- ST_SETUP: psel_o=1, penable_o=0, hreadyout_o=0; go to ST_ACCESS.
- ST_ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata/pstrb held stable.
  - pready_i=1 & pslverr_i=0: register prdata_i→hrdata_o (reads only); go to ST_IDLE.
  - pready_i=1 & pslverr_i=1: go to ST_ERR1.
  - Timeout: if TIMEOUT_CYC>0 and the wait counter reaches TIMEOUT_CYC, deassert psel/penable and go to ST_ERR1. The counter clears on entry to ACCESS.
- ST_ERR1: hreadyout_o=0, hresp_o=1; go to ST_ERR2.
- ST_ERR2: hreadyout_o=1, hresp_o=1; go to ST_IDLE. No new transfer is accepted in ERR2.
- Latency, zero-wait peripheral:
  - Read: hreadyout_o low for 2 cycles after the address phase; data valid with hreadyout_o=1 on the 3rd.
  - Write: low for 3 cycles.
- Back-to-back: the ST_IDLE cycle that completes a transfer may accept the next address phase.
- psel_o and penable_o are both 0 outside SETUP/ACCESS. paddr_o and pwdata_o retain their last value.
- Strobes: bytes [haddr mod (DATA_W/8)] through [+2^hsize-1] are set.

Decomposition:
- Package ahb_apb_pkg: bridge_state_t enum (ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2); HTRANS_IDLE/BUSY/NONSEQ/SEQ constants; HRESP_OKAY/ERROR constants.
- Sub-module apb_strb_gen: combinational hsize/haddr → pstrb, parametrised on DATA_W.

Test Plan:
1. Read 0x0000A000, pready_i=1, prdata_i=0xDEADBEEF → psel 1 cycle then psel+penable 1 cycle; hrdata_o=0xDEADBEEF, hresp_o=0 on 3rd cycle.
2. Word write 0xA004 data 0x12345678, pready_i low 3 cycles → ACCESS held 4 cycles; pwdata_o=0x12345678, pstrb_o=4'hF stable throughout.
3. Byte write 0xA003, hsize=0 → pstrb_o=4'b1000; halfword write 0xA002 → pstrb_o=4'b1100.
4. Read with pslverr_i=1 → hresp_o=1 for 2 cycles, hreadyout_o 0 then 1; next transfer OKAY.
5. TIMEOUT_CYC=4, pready_i held 0 → psel_o drops after 4 ACCESS cycles, then ERROR response; hsize=3 with DATA_W=32 → ERROR, psel_o never asserted.
6. preset_n pulsed low during ACCESS → all outputs at reset values immediately; after release, a read to 0xA000 completes normally.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared types and bus encodings for the AHB-Lite to APB bridge.
//   bridge_state_t : bridge FSM states
//   HTRANS_*       : AHB transfer type encodings
//   HRESP_*        : AHB response encodings
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_strb_gen.sv
// apb_strb_gen: combinational byte-strobe generator.
//   addr_lo_i : low address bits selecting the first byte lane
//   hsize_i   : AHB transfer size (2^hsize_i bytes)
//   strb_o    : one bit per byte lane of the DATA_W data bus
module apb_strb_gen
  import ahb_apb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [OFF_W-1:0] addr_lo_i,
  input  logic [2:0]       hsize_i,
  output logic [NB-1:0]    strb_o
);

  logic [31:0] off;
  logic [31:0] len;

  always_comb begin
    // A one-lane bus has no lane offset at all.
    off = (NB > 1) ? 32'(addr_lo_i) : 32'd0;
    len = 32'd1 << hsize_i;
  end

  // Lane gi is active when it falls inside [off, off + len).
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign strb_o[gi] = (32'(gi) >= off) && (32'(gi) < off + len);
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// ahb_apb_bridge_param: AHB-Lite slave to APB master bridge.
//   AHB side : hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i
//              -> hreadyout_o, hresp_o, hrdata_o
//   APB side : psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
//              <- prdata_i, pready_i, pslverr_i
// Supports APB wait states, pslverr -> two-cycle AHB ERROR, byte strobes,
// oversize-transfer rejection and an optional ACCESS timeout.
module ahb_apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                preset_n,
  input  logic                hsel_i,
  input  logic [ADDR_W-1:0]   haddr_i,
  input  logic [1:0]          htrans_i,
  input  logic                hwrite_i,
  input  logic [2:0]          hsize_i,
  input  logic [DATA_W-1:0]   hwdata_i,
  input  logic                hready_i,
  output logic                hreadyout_o,
  output logic                hresp_o,
  output logic [DATA_W-1:0]   hrdata_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int NB       = DATA_W / 8;
  localparam int OFF_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int MAX_SIZE = $clog2(NB);
  localparam int CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [NB-1:0]     pstrb_q, pstrb_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NB-1:0] strb_w;
  logic          xfer_valid;
  logic          oversize;
  logic          timeout_hit;

  apb_strb_gen #(.DATA_W(DATA_W)) u_strb (
    .addr_lo_i (haddr_i[OFF_W-1:0]),
    .hsize_i   (hsize_i),
    .strb_o    (strb_w)
  );

  assign xfer_valid = hsel_i && hready_i &&
                      ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
  assign oversize   = hsize_i > 3'(MAX_SIZE);
  // cnt_q counts completed ACCESS cycles; this cycle would be number cnt_q+1.
  assign timeout_hit = (TIMEOUT_CYC > 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYC);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_valid) begin
          paddr_d  = haddr_i;
          pwrite_d = hwrite_i;
          pstrb_d  = hwrite_i ? strb_w : '0;
          if (oversize)      state_d = ST_ERR1;
          else if (hwrite_i) state_d = ST_WDATA;
          else               state_d = ST_SETUP;
        end
      end
      ST_WDATA: begin
        pwdata_d = hwdata_i;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          if (pslverr_i) begin
            state_d = ST_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = prdata_i;
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Control outputs decode straight from the state so reset takes effect at once.
  assign hreadyout_o = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign hresp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
module tb_ahb_apb_bridge_param;
  import ahb_apb_pkg::*;

  logic        clk;
  logic        preset_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready;
  int          rsp_waits;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  ahb_apb_bridge_param #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .preset_n    (preset_n),
    .hsel_i      (hsel),
    .haddr_i     (haddr),
    .htrans_i    (htrans),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hwdata_i    (hwdata),
    .hready_i    (hreadyout_o),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hrdata_o    (hrdata_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .prdata_i    (rsp_rdata),
    .pready_i    (pready),
    .pslverr_i   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          waits;
    logic        resp;
    logic        rd;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB responder: pready after rsp_waits wait cycles in ACCESS.
  initial begin
    int acc_k;
    acc_k  = 0;
    pready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (psel_o && penable_o) begin
        pready = (acc_k >= rsp_waits);
        acc_k++;
      end else begin
        acc_k  = 0;
        pready = 1'b0;
      end
    end
  end

  // AHB response monitor.
  initial begin
    bit       in_dp;
    int       dp_waits;
    logic     prev_hresp;
    ahb_exp_t e;
    in_dp = 0;
    dp_waits = 0;
    prev_hresp = 1'b0;
    forever begin
      @(negedge clk);
      if (!preset_n) begin
        ahb_q.delete();
        in_dp = 0;
      end else begin
        if (in_dp) begin
          if (hreadyout_o) begin
            if (ahb_q.size() == 0) begin
              chk("ahb_unexpected_completion", 1, 0);
            end else begin
              e = ahb_q.pop_front();
              chk("ahb_wait_cycles", dp_waits, e.waits);
              chk("ahb_hresp", hresp_o, e.resp);
              if (e.rd) chk("ahb_hrdata", hrdata_o, e.rdata);
              if (e.resp) chk("ahb_err_first_cycle", prev_hresp, 1);
              $display("AHB txn: waits=%0d hresp=%0d hrdata=%08h", dp_waits, hresp_o, hrdata_o);
            end
            in_dp = 0;
          end else begin
            dp_waits++;
          end
        end
        if (hsel && hreadyout_o && htrans[1]) begin
          in_dp = 1;
          dp_waits = 0;
        end
      end
      prev_hresp = hresp_o;
    end
  end

  // APB access monitor: fields must be stable over every ACCESS cycle.
  initial begin
    bit       in_acc;
    int       acc_n;
    apb_exp_t e;
    in_acc = 0;
    acc_n = 0;
    forever begin
      @(negedge clk);
      if (!preset_n) begin
        apb_q.delete();
        in_acc = 0;
        acc_n = 0;
      end else if (psel_o && penable_o) begin
        if (apb_q.size() == 0) begin
          chk("apb_unexpected_access", 1, 0);
        end else begin
          e = apb_q[0];
          chk("apb_paddr", paddr_o, e.addr);
          chk("apb_pwrite", pwrite_o, e.wr);
          chk("apb_pstrb", pstrb_o, e.strb);
          if (e.wr) chk("apb_pwdata", pwdata_o, e.wdata);
        end
        acc_n++;
        in_acc = 1;
      end else if (in_acc) begin
        if (apb_q.size() != 0) begin
          e = apb_q.pop_front();
          chk("apb_access_cycles", acc_n, e.acc);
          $display("APB txn: addr=%08h wr=%0d strb=%h access_cycles=%0d", e.addr, e.wr, e.strb, acc_n);
        end
        in_acc = 0;
        acc_n = 0;
      end else if (psel_o && apb_q.size() == 0) begin
        chk("apb_unexpected_setup", 1, 0);
      end
    end
  end

  // Called at posedge+1 with the bus ready; returns when the bus is ready again.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                       input logic err, input int exp_wait, input logic exp_resp,
                       input logic apb, input logic [3:0] exp_strb, input int exp_acc);
    ahb_exp_t a;
    apb_exp_t p;
    rsp_waits = waits;
    rsp_rdata = rdata;
    rsp_err   = err;
    a.waits = exp_wait;
    a.resp  = exp_resp;
    a.rd    = !wr && !exp_resp;
    a.rdata = rdata;
    ahb_q.push_back(a);
    if (apb) begin
      p.addr  = addr;
      p.wr    = wr;
      p.wdata = wdata;
      p.strb  = exp_strb;
      p.acc   = exp_acc;
      apb_q.push_back(p);
    end
    hsel = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = size;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
    for (int i = 0; i < 64 && !hreadyout_o; i++) begin
      @(posedge clk);
      #1;
    end
    if (!hreadyout_o) chk("issue_bus_timeout", 0, 1);
    // The ERR2 cycle accepts no new transfer.
    if (exp_resp) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    rsp_waits = 0; rsp_rdata = '0; rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", hreadyout_o, 1);
    chk("rst_hresp", hresp_o, 0);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pstrb", pstrb_o, 0);
    preset_n = 1'b1;
    @(posedge clk);
    #1;

    //    addr         wr    sz    wdata         waits rdata          err   ew rsp   apb  strb  acc
    issue(32'h0000A000, 1'b0, 3'd2, 32'h0,        0,  32'hDEADBEEF, 1'b0, 2, 1'b0, 1'b1, 4'h0, 1);
    issue(32'h0000A004, 1'b1, 3'd2, 32'h12345678, 3,  32'h0,        1'b0, 6, 1'b0, 1'b1, 4'hF, 4);
    issue(32'h0000A003, 1'b1, 3'd0, 32'hAB000000, 0,  32'h0,        1'b0, 3, 1'b0, 1'b1, 4'h8, 1);
    issue(32'h0000A002, 1'b1, 3'd1, 32'hCDEF0000, 0,  32'h0,        1'b0, 3, 1'b0, 1'b1, 4'hC, 1);
    issue(32'h0000A001, 1'b1, 3'd0, 32'h00110000, 0,  32'h0,        1'b0, 3, 1'b0, 1'b1, 4'h2, 1);
    issue(32'h0000A008, 1'b0, 3'd2, 32'h0,        1,  32'h0BADF00D, 1'b0, 3, 1'b0, 1'b1, 4'h0, 2);
    // Slave error then a clean read.
    issue(32'h0000A010, 1'b0, 3'd2, 32'h0,        0,  32'h11111111, 1'b1, 3, 1'b1, 1'b1, 4'h0, 1);
    issue(32'h0000A014, 1'b0, 3'd2, 32'h0,        0,  32'h55AA55AA, 1'b0, 2, 1'b0, 1'b1, 4'h0, 1);
    // Timeout after 4 ACCESS cycles, then an oversize transfer.
    issue(32'h0000A020, 1'b0, 3'd2, 32'h0,        255, 32'h22222222, 1'b0, 6, 1'b1, 1'b1, 4'h0, 4);
    issue(32'h0000A024, 1'b0, 3'd3, 32'h0,        0,  32'h33333333, 1'b0, 1, 1'b1, 1'b0, 4'h0, 0);
    issue(32'h0000A030, 1'b1, 3'd2, 32'h0F0F0F0F, 1,  32'h0,        1'b1, 5, 1'b1, 1'b1, 4'hF, 2);
    // Back-to-back pair (second address phase rides the completing IDLE cycle).
    issue(32'h0000A040, 1'b0, 3'd2, 32'h0,        0,  32'h76543210, 1'b0, 2, 1'b0, 1'b1, 4'h0, 1);
    issue(32'h0000A044, 1'b1, 3'd1, 32'h0000BEEF, 0,  32'h0,        1'b0, 3, 1'b0, 1'b1, 4'h3, 1);

    // Reset pulsed in the middle of an ACCESS that never gets pready.
    @(posedge clk);
    #1;
    begin
      ahb_exp_t a;
      apb_exp_t p;
      a.waits = 0; a.resp = 1'b0; a.rd = 1'b1; a.rdata = '0;
      ahb_q.push_back(a);
      p.addr = 32'h0000A050; p.wr = 1'b0; p.wdata = '0; p.strb = 4'h0; p.acc = 0;
      apb_q.push_back(p);
    end
    rsp_waits = 255;
    hsel = 1'b1; haddr = 32'h0000A050; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    for (int i = 0; i < 16 && !(psel_o && penable_o); i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_access", penable_o, 1);
    #1;
    preset_n = 1'b0;
    #1;
    chk("arst_hreadyout", hreadyout_o, 1);
    chk("arst_hresp", hresp_o, 0);
    chk("arst_hrdata", hrdata_o, 0);
    chk("arst_psel", psel_o, 0);
    chk("arst_penable", penable_o, 0);
    chk("arst_pwrite", pwrite_o, 0);
    chk("arst_paddr", paddr_o, 0);
    chk("arst_pwdata", pwdata_o, 0);
    chk("arst_pstrb", pstrb_o, 0);
    @(posedge clk);
    #1;
    preset_n = 1'b1;
    rsp_waits = 0;
    @(posedge clk);
    #1;
    issue(32'h0000A000, 1'b0, 3'd2, 32'h0,        0,  32'h600DCAFE, 1'b0, 2, 1'b0, 1'b1, 4'h0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("ahb_queue_drained", ahb_q.size(), 0);
    chk("apb_queue_drained", apb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
